// File: rtl/pc_gen_ras.sv
// Fetch-stage program counter with prioritised redirects (trap, then EX redirect),
// call/return hint prediction and a small circular return-address stack.
module pc_gen_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_target,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         pred_call,
  input  logic [XLEN-1:0]              pred_call_target,
  input  logic                         pred_ret,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_valid,
  output logic                         misalign_err,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned     PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] INC        = XLEN'(1) << ALIGN_BITS;
  localparam logic [XLEN-1:0] ALIGN_MASK = INC - XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic             r_pc_valid;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_top;          // next free slot; top entry sits at r_top-1
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];

  logic [XLEN-1:0]  w_pc_inc;
  logic [XLEN-1:0]  w_raw;
  logic [XLEN-1:0]  w_next_pc;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_top_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_load;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_misalign_next;

  assign w_pc_inc  = r_pc + INC;
  assign w_top_idx = r_top - PTR_W'(1);

  // Hints are ignored until the PC is valid, so no push/pop can happen in reset.
  always_comb begin
    w_raw   = '0;
    w_load  = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    w_next_pc = r_pc;
    if (trap_valid) begin
      w_raw   = trap_target;
      w_load  = 1'b1;
      w_clear = 1'b1;
    end else if (redirect_valid) begin
      w_raw  = redirect_target;
      w_load = 1'b1;
    end else if (stall || !r_pc_valid) begin
      w_next_pc = r_pc;
    end else if (pred_ret) begin
      if (r_count != '0) begin
        w_raw  = r_ras[w_top_idx];
        w_load = 1'b1;
        w_pop  = 1'b1;
      end else begin
        w_next_pc = w_pc_inc;
      end
    end else if (pred_call) begin
      w_raw  = pred_call_target;
      w_load = 1'b1;
      w_push = 1'b1;
    end else begin
      w_next_pc = w_pc_inc;
    end
    if (w_load) begin
      w_next_pc = w_raw & ~ALIGN_MASK;
    end
  end

  assign w_misalign_next = w_load && ((w_raw & ALIGN_MASK) != '0);

  always_comb begin
    w_count_next = r_count;
    w_top_next   = r_top;
    if (w_clear) begin
      w_count_next = '0;
      w_top_next   = '0;
    end else if (w_pop) begin
      w_count_next = r_count - CNT_W'(1);
      w_top_next   = r_top - PTR_W'(1);
    end else if (w_push) begin
      // A full stack overwrites its oldest entry; the count saturates.
      w_count_next = (r_count == CNT_FULL) ? r_count : r_count + CNT_W'(1);
      w_top_next   = r_top + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
      r_top      <= '0;
    end else begin
      r_pc       <= w_next_pc;
      r_pc_valid <= 1'b1;
      r_misalign <= w_misalign_next;
      r_count    <= w_count_next;
      r_top      <= w_top_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_top] <= w_pc_inc;
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign misalign_err = r_misalign;
  assign ras_count    = r_count;

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
Parametrised program-counter generator for the fetch stage. Generalises the single-jump PC register in four ways: width and reset vector are parameters; redirect sources are prioritised (trap, then resolved branch/jump); fetch-time call/return hints are predicted; a small circular return-address stack (RAS) backs the return predictions. It sits ahead of instruction memory and feeds the IF/ID pipeline register.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.
ALIGN_BITS, 2, number of low PC bits that must be zero; the increment is 2**ALIGN_BITS.

Ports:
clk  in  1  Clock. All state changes on the rising edge.
rst_n  in  1  Reset. Asynchronous assertion, active-low.
stall  in  1  Hold the PC; fetch hints are ignored while it is high.
trap_valid  in  1  Trap or exception redirect.
trap_target  in  XLEN  Trap handler address.
redirect_valid  in  1  Resolved branch/jump redirect from EX.
redirect_target  in  XLEN  Target address for the EX redirect.
pred_call  in  1  The instruction at pc is a call (JAL with rd=x1).
pred_call_target  in  XLEN  Precomputed call target.
pred_ret  in  1  The instruction at pc is a return (JALR x0,0(x1)).
pc  out  XLEN  Current PC. Registered; stable for the whole cycle.
pc_valid  out  1  pc holds a fetchable address.
misalign_err  out  1  One-cycle pulse: the last loaded target had nonzero low bits.
ras_count  out  $clog2(RAS_DEPTH)+1  Number of valid RAS entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_VECTOR, pc_valid=0, misalign_err=0, ras_count=0, RAS top pointer=0.
  - RAS entry contents are don't-care.
  - The first rising edge after rst_n goes high sets pc_valid=1 and leaves pc unchanged. pc_valid then stays 1 until the next reset.
  - Reset asserted mid-operation aborts any pending push or pop immediately.
- Next-PC priority, evaluated combinationally each cycle and registered at the edge (inc = 2**ALIGN_BITS, sums wrap modulo 2**XLEN):
  1. trap_valid: next=trap_target. RAS is cleared (ras_count=0).
  2. redirect_valid: next=redirect_target. RAS is untouched.
  3. stall: next=pc. No push, no pop, no misalign pulse.
  4. pred_ret with ras_count>0: next=RAS top. Pop, ras_count-1.
  5. pred_ret with ras_count=0: next=pc+inc. No pop. Treated as a mispredict left to EX to correct.
  6. pred_call: next=pred_call_target. Push pc+inc, ras_count+1, saturating at RAS_DEPTH.
  7. Otherwise: next=pc+inc.
- Trap and redirect override stall.
- Before pc_valid=1, the priority list still applies, except that hints are ignored and pc does not advance.
- If pred_call and pred_ret are both high, pred_ret wins and there is no push.
- Alignment:
  - Any target loaded from priorities 1, 2, 4 or 6 is written with its low ALIGN_BITS forced to 0.
  - misalign_err=1 in the cycle after the load iff the original target's low bits were nonzero. Otherwise misalign_err=0.
- RAS organisation:
  - Circular buffer indexed by a top pointer of $clog2(RAS_DEPTH) bits.
  - A push when full overwrites the oldest entry; ras_count stays at RAS_DEPTH and the pointer wraps.
  - A pop decrements the pointer modulo RAS_DEPTH.
  - Push and pop never occur in the same cycle.
- No combinational path from any input to pc. misalign_err and ras_count are registered.

Test Plan:
- Reset and sequential run (RESET_VECTOR=32'h100): release rst_n, no inputs → pc=0x100 for 2 cycles (pc_valid goes 1 after the first edge), then 0x104, 0x108. Assert rst_n low mid-cycle → pc=0x100 and pc_valid=0 immediately, without waiting for a clock edge.
- Priority collision: at pc=0x200, drive trap_valid (0x800), redirect_valid (0x400) and stall together → pc=0x800, ras_count=0. Next cycle, redirect (0x400) with stall → pc=0x400. Next cycle, stall alone → pc holds 0x400.
- Call/return pairing: at pc=0x10, pred_call with target 0x80 → pc=0x80, ras_count=1. Two sequential cycles → pc=0x84, 0x88. pred_ret at 0x88 → pc=0x14, ras_count=0.
- RAS overflow (RAS_DEPTH=4): 5 nested calls from 0x00, 0x100, 0x200, 0x300, 0x400 → ras_count=4. Then 4 returns → pc=0x404, 0x304, 0x204, 0x104. A 5th return → sequential pc+4, ras_count=0.
- Misalignment: redirect_target=0x1002 → pc=0x1000 and misalign_err=1 for exactly one cycle. Next redirect to 0x2000 → misalign_err=0.
- Wrap and edge hints: at pc=32'hFFFF_FFFC, sequential → pc=0x0. pred_ret with ras_count=0 → pc+4, no pop. pred_call and pred_ret both high with ras_count=1 → pop wins, no push.
